// File: rtl/regfile_ctrl.sv
// Register-file sequencer: clears all registers after reset, then arbitrates the single
// rf port between requester A and requester B round-robin, returning read data one cycle later.
module regfile_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_rs1_addr,
  input  logic [ADDR_W-1:0] a_rs2_addr,
  input  logic [ADDR_W-1:0] a_rd_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_rs1_addr,
  input  logic [ADDR_W-1:0] b_rs2_addr,
  input  logic [ADDR_W-1:0] b_rd_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              a_gnt,
  output logic              b_gnt,
  output logic              a_rvalid,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] a_rdata1,
  output logic [DATA_W-1:0] a_rdata2,
  output logic [DATA_W-1:0] b_rdata1,
  output logic [DATA_W-1:0] b_rdata2,
  output logic              busy,
  output logic [ADDR_W-1:0] rf_rs1_addr,
  output logic [ADDR_W-1:0] rf_rs2_addr,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic [DATA_W-1:0] rf_rd_data,
  output logic              rf_r_w,
  input  logic [DATA_W-1:0] rf_rs1_data,
  input  logic [DATA_W-1:0] rf_rs2_data
);

  localparam logic [ADDR_W:0] ClrLast = {1'b0, {ADDR_W{1'b1}}};

  typedef enum logic [0:0] {StInit, StRun} state_e;

  state_e          state_q, state_d;
  logic [ADDR_W:0] clr_cnt_q, clr_cnt_d;
  // 0: A wins the next contention, 1: B wins it
  logic            rr_q, rr_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StInit;
      clr_cnt_q <= '0;
      rr_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
      rr_q      <= rr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    rr_d      = rr_q;
    case (state_q)
      StInit: begin
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == ClrLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (a_gnt) begin
          rr_d = 1'b1;
        end else if (b_gnt) begin
          rr_d = 1'b0;
        end
      end
      default: state_d = StInit;
    endcase
  end

  always_comb begin
    a_gnt       = 1'b0;
    b_gnt       = 1'b0;
    busy        = 1'b0;
    rf_r_w      = 1'b1;
    rf_rs1_addr = '0;
    rf_rs2_addr = '0;
    rf_rd_addr  = '0;
    rf_rd_data  = '0;
    case (state_q)
      StInit: begin
        busy       = 1'b1;
        rf_r_w     = 1'b0;
        rf_rd_addr = clr_cnt_q[ADDR_W-1:0];
      end
      StRun: begin
        // A grant issued while reset is high would be thrown away, so none is offered
        if (!reset) begin
          a_gnt = a_req & (~b_req | ~rr_q);
          b_gnt = b_req & (~a_req | rr_q);
        end
        if (a_gnt) begin
          rf_r_w      = ~a_we;
          rf_rs1_addr = a_rs1_addr;
          rf_rs2_addr = a_rs2_addr;
          rf_rd_addr  = a_rd_addr;
          rf_rd_data  = a_wdata;
        end else if (b_gnt) begin
          rf_r_w      = ~b_we;
          rf_rs1_addr = b_rs1_addr;
          rf_rs2_addr = b_rs2_addr;
          rf_rd_addr  = b_rd_addr;
          rf_rd_data  = b_wdata;
        end
      end
      default: busy = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata1 <= '0;
      a_rdata2 <= '0;
      b_rdata1 <= '0;
      b_rdata2 <= '0;
    end else begin
      a_rvalid <= a_gnt & ~a_we;
      b_rvalid <= b_gnt & ~b_we;
      if (a_gnt && !a_we) begin
        a_rdata1 <= rf_rs1_data;
        a_rdata2 <= rf_rs2_data;
      end
      if (b_gnt && !b_we) begin
        b_rdata1 <= rf_rs1_data;
        b_rdata2 <= rf_rs2_data;
      end
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: register-file model on the rf port, array/queue reference model
// for grants and read data, and a separate monitor that pops expected reads on rvalid.
module tb_regfile_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned NREG   = 8;

  logic              clk, reset;
  logic              a_req, a_we, b_req, b_we;
  logic [ADDR_W-1:0] a_rs1_addr, a_rs2_addr, a_rd_addr;
  logic [ADDR_W-1:0] b_rs1_addr, b_rs2_addr, b_rd_addr;
  logic [DATA_W-1:0] a_wdata, b_wdata;
  logic              a_gnt, b_gnt, a_rvalid, b_rvalid, busy, rf_r_w;
  logic [DATA_W-1:0] a_rdata1, a_rdata2, b_rdata1, b_rdata2;
  logic [ADDR_W-1:0] rf_rs1_addr, rf_rs2_addr, rf_rd_addr;
  logic [DATA_W-1:0] rf_rd_data, rf_rs1_data, rf_rs2_data;

  logic [DATA_W-1:0] rf_mem [NREG];

  int                n_vec = 0;
  int                n_err = 0;
  logic [DATA_W-1:0] m_regs [NREG];
  int                m_left;
  logic              m_rr;
  logic [2*DATA_W-1:0] qa[$];
  logic [2*DATA_W-1:0] qb[$];
  logic              a_pend, b_pend, last_a, last_b;

  regfile_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_rs1_addr(a_rs1_addr), .a_rs2_addr(a_rs2_addr),
    .a_rd_addr(a_rd_addr), .a_wdata(a_wdata),
    .b_req(b_req), .b_we(b_we), .b_rs1_addr(b_rs1_addr), .b_rs2_addr(b_rs2_addr),
    .b_rd_addr(b_rd_addr), .b_wdata(b_wdata),
    .a_gnt(a_gnt), .b_gnt(b_gnt), .a_rvalid(a_rvalid), .b_rvalid(b_rvalid),
    .a_rdata1(a_rdata1), .a_rdata2(a_rdata2), .b_rdata1(b_rdata1), .b_rdata2(b_rdata2),
    .busy(busy), .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data), .rf_r_w(rf_r_w),
    .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Register file with garbage power-up contents so a missing clear shows up
  initial begin
    for (int i = 0; i < NREG; i++) rf_mem[i] = DATA_W'(8'hA0 + i);
  end
  always @(posedge clk) begin
    if (rf_r_w === 1'b0) rf_mem[rf_rd_addr] <= rf_rd_data;
  end
  assign rf_rs1_data = rf_mem[rf_rs1_addr];
  assign rf_rs2_data = rf_mem[rf_rs2_addr];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: sweep countdown, round-robin pointer, register array, expected-read queues
  task automatic model_step();
    logic ea, eb;
    logic [17:0] bus;
    bus = {rf_r_w, rf_rs1_addr, rf_rs2_addr, rf_rd_addr, rf_rd_data};
    if (reset) begin
      check("rst_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      m_left = NREG;
      m_rr   = 1'b0;
      return;
    end
    if (m_left > 0) begin
      check("init_busy", {31'd0, busy}, 32'd1);
      check("init_gnt", {30'd0, a_gnt, b_gnt}, 32'd0);
      check("init_bus", {rf_r_w, rf_rd_addr, rf_rd_data},
            {1'b0, ADDR_W'(NREG - m_left), 8'h00});
      m_regs[NREG-m_left] = '0;
      m_left--;
      return;
    end
    check("run_busy", {31'd0, busy}, 32'd0);
    if (a_req && b_req) begin
      ea = ~m_rr;
      eb = m_rr;
    end else begin
      ea = a_req;
      eb = b_req;
    end
    check("gnt", {30'd0, a_gnt, b_gnt}, {30'd0, ea, eb});
    if (ea) begin
      check("bus_a", bus, {~a_we, a_rs1_addr, a_rs2_addr, a_rd_addr, a_wdata});
      if (a_we) m_regs[a_rd_addr] = a_wdata;
      else qa.push_back({m_regs[a_rs1_addr], m_regs[a_rs2_addr]});
      m_rr = 1'b1;
    end else if (eb) begin
      check("bus_b", bus, {~b_we, b_rs1_addr, b_rs2_addr, b_rd_addr, b_wdata});
      if (b_we) m_regs[b_rd_addr] = b_wdata;
      else qb.push_back({m_regs[b_rs1_addr], m_regs[b_rs2_addr]});
      m_rr = 1'b0;
    end else begin
      check("bus_idle", bus, {1'b1, 17'd0});
    end
  endtask

  // Monitor: registered outputs settle after the edge; compare against queued expectations
  always @(posedge clk) begin
    logic [2*DATA_W-1:0] e;
    #1;
    check("a_rvalid", {31'd0, a_rvalid}, {31'd0, qa.size() > 0});
    if (qa.size() > 0) begin
      e = qa.pop_front();
      if (a_rvalid) check("a_rdata", {16'd0, a_rdata1, a_rdata2}, {16'd0, e});
    end
    check("b_rvalid", {31'd0, b_rvalid}, {31'd0, qb.size() > 0});
    if (qb.size() > 0) begin
      e = qb.pop_front();
      if (b_rvalid) check("b_rdata", {16'd0, b_rdata1, b_rdata2}, {16'd0, e});
    end
  end

  task automatic tick();
    #1;
    model_step();
    last_a = a_gnt;
    last_b = b_gnt;
    if (a_gnt) a_pend = 1'b0;
    if (b_gnt) b_pend = 1'b0;
    @(negedge clk);
  endtask

  task automatic rand_drive();
    if (!a_pend && $urandom_range(0, 2) != 0) begin
      a_pend = 1'b1;
      a_we = 1'($urandom_range(0, 1));
      a_rs1_addr = ADDR_W'($urandom);
      a_rs2_addr = ADDR_W'($urandom);
      a_rd_addr = ADDR_W'($urandom);
      a_wdata = DATA_W'($urandom);
    end
    if (!b_pend && $urandom_range(0, 2) != 0) begin
      b_pend = 1'b1;
      b_we = 1'($urandom_range(0, 1));
      b_rs1_addr = ADDR_W'($urandom);
      b_rs2_addr = ADDR_W'($urandom);
      b_rd_addr = ADDR_W'($urandom);
      b_wdata = DATA_W'($urandom);
    end
    a_req = a_pend;
    b_req = b_pend;
  endtask

  initial begin
    reset = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_rs1_addr = '0; a_rs2_addr = '0; a_rd_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_rs1_addr = '0; b_rs2_addr = '0; b_rd_addr = '0; b_wdata = '0;
    a_pend = 1'b0; b_pend = 1'b0;
    m_left = NREG; m_rr = 1'b0;
    for (int i = 0; i < NREG; i++) m_regs[i] = '0;

    tick();
    tick();
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_bus", {20'd0, rf_r_w, rf_rd_addr, rf_rd_data}, 32'd0);
    check("rst_rvalid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check("rst_rdata", {a_rdata1, a_rdata2, b_rdata1, b_rdata2}, 32'd0);
    reset = 1'b0;
    repeat (NREG) tick();

    // Contention from a fresh pointer alternates A, B, A, ...
    a_we = 1'b0; b_we = 1'b0;
    for (int i = 0; i < 6; i++) begin
      a_req = 1'b1; b_req = 1'b1;
      a_rs1_addr = ADDR_W'(i); b_rs2_addr = ADDR_W'(7 - i);
      tick();
      check("alt_gnt", {30'd0, last_a, last_b}, (i % 2 == 0) ? 32'd2 : 32'd1);
    end

    // A alone keeps winning; then B wins the first contention
    b_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("a_alone", {31'd0, last_a}, 32'd1);
    end
    b_req = 1'b1;
    tick();
    check("b_first", {30'd0, last_a, last_b}, 32'd1);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    for (int i = 0; i < NREG; i++) begin
      a_req = 1'b1; a_we = 1'b0;
      a_rs1_addr = ADDR_W'(i); a_rs2_addr = ADDR_W'(NREG - 1 - i);
      tick();
    end
    a_req = 1'b0;
    tick();

    b_req = 1'b1; b_we = 1'b1; b_rd_addr = 3'd3; b_wdata = 8'h5A;
    tick();
    check("b_wr_gnt", {31'd0, last_b}, 32'd1);
    b_req = 1'b0; a_req = 1'b1; a_we = 1'b0; a_rs1_addr = 3'd3; a_rs2_addr = 3'd0;
    tick();
    check("a_rd_gnt", {31'd0, last_a}, 32'd1);
    a_req = 1'b0;
    check("raw_valid", {30'd0, a_rvalid, b_rvalid}, 32'd2);
    check("raw_data", {16'd0, a_rdata1, a_rdata2}, 32'h5A00);
    tick();

    // Reset four cycles into the sweep: the sweep restarts, requests wait throughout
    reset = 1'b1;
    tick();
    reset = 1'b0;
    a_req = 1'b1; b_req = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    repeat (NREG) tick();
    tick();
    check("post_init_gnt", {30'd0, last_a, last_b}, 32'd2);
    a_req = 1'b0; b_req = 1'b0;
    tick();

    // Read in flight, then reset: data registers come back cleared, no stray rvalid
    a_req = 1'b1; a_we = 1'b1; a_rd_addr = 3'd3; a_wdata = 8'h5A;
    tick();
    a_we = 1'b0; a_rs1_addr = 3'd3; a_rs2_addr = 3'd3;
    tick();
    reset = 1'b1;
    tick();
    check("rst_rd_valid", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    check("rst_rd_data", {24'd0, a_rdata1}, 32'd0);
    reset = 1'b0; a_req = 1'b0;
    repeat (NREG) tick();

    for (int i = 0; i < 400; i++) begin
      rand_drive();
      tick();
    end
    a_req = 1'b0; b_req = 1'b0;
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
